// File: rtl/pe_os_mac.sv
// Output-stationary bfloat16 MAC cell with N-term reduction, clear-on-first-term and a drain chain.
// Latency: operands forwarded after 1 cycle; result captured on the final term (1 cycle later with PE_MUL_PIPE_EN).
// Backpressure: none, operands are valid-qualified and iDrain is a controller-driven shift strobe.
module pe_os_mac #(
    parameter int BW = 16,
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iValid,
    input  logic          iClear,
    input  logic [BW-1:0] iRow,
    input  logic [BW-1:0] iCol,
    input  logic          iDrain,
    input  logic [BW-1:0] iRes,
    output logic          oValid,
    output logic          oClear,
    output logic [BW-1:0] oRow,
    output logic [BW-1:0] oCol,
    output logic [BW-1:0] oRes,
    output logic          oDone,
    output logic [CW-1:0] oCnt
);
    logic [BW-1:0] prod, acc, add_a, sum, a_prod;
    logic          a_vld, a_clr, final_term;
    logic [CW:0]   cnt_nxt;

    bfloat16Multiplier u_mul (.a(iRow), .b(iCol), .y(prod));

`ifdef PE_MUL_PIPE_EN
    logic          p_vld, p_clr;
    logic [BW-1:0] p_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_vld  <= 1'b0;
            p_clr  <= 1'b0;
            p_prod <= '0;
        end else begin
            p_vld  <= iValid;
            p_clr  <= iClear;
            p_prod <= prod;
        end
    end

    assign a_vld  = p_vld;
    assign a_clr  = p_clr;
    assign a_prod = p_prod;
`else
    assign a_vld  = iValid;
    assign a_clr  = iClear;
    assign a_prod = prod;
`endif

    // A clearing term starts from +0 so the abandoned partial sum never leaks in.
    assign add_a = a_clr ? '0 : acc;

    bfloat16Add u_add (.a(add_a), .b(a_prod), .y(sum));

    assign cnt_nxt    = a_clr ? (CW+1)'(1) : {1'b0, oCnt} + (CW+1)'(1);
    assign final_term = a_vld && (cnt_nxt == (CW+1)'(N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oValid <= 1'b0;
            oClear <= 1'b0;
            oRow   <= '0;
            oCol   <= '0;
            oRes   <= '0;
            oDone  <= 1'b0;
            oCnt   <= '0;
            acc    <= '0;
        end else begin
            oValid <= iValid;
            oClear <= iValid & iClear;
            if (iValid) begin
                oRow <= iRow;
                oCol <= iCol;
            end
            oDone <= final_term;
            if (final_term) begin
                // Capture takes priority over a coincident drain step.
                oRes <= sum;
                acc  <= '0;
                oCnt <= '0;
            end else begin
                if (a_vld) begin
                    acc  <= sum;
                    oCnt <= cnt_nxt[CW-1:0];
                end else if (a_clr) begin
                    acc  <= '0;
                    oCnt <= '0;
                end
                if (iDrain)
                    oRes <= iRes;
            end
        end
    end
endmodule

// bfloat16 multiply, round-to-nearest-even, subnormals flushed to signed zero.
// Latency: combinational.
// Backpressure: none.
module bfloat16Multiplier (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st, up;
    logic [15:0]       p;
    logic [6:0]        fr;
    logic signed [9:0] e;
    logic [16:0]       r;

    always_comb begin
        sgn    = a[15] ^ b[15];
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        a_zero = (a[14:7] == 8'd0);
        b_zero = (b[14:7] == 8'd0);
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
        if (p[15]) begin
            fr = p[14:8];
            g  = p[7];
            st = |p[6:0];
            e  = e + 10'sd1;
        end else begin
            fr = p[13:7];
            g  = p[6];
            st = |p[5:0];
        end
        up = g & (st | fr[0]);
        // Rounding carry out of the fraction ripples straight into the exponent.
        r  = {e, fr} + {16'd0, up};
        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
            y = 16'h7FC0;
        else if (a_inf | b_inf)
            y = {sgn, 8'hFF, 7'd0};
        else if (a_zero | b_zero)
            y = {sgn, 15'd0};
        else if ($signed(r[16:7]) >= 10'sd255)
            y = {sgn, 8'hFF, 7'd0};
        else if ($signed(r[16:7]) <= 10'sd0)
            y = {sgn, 15'd0};
        else
            y = {sgn, r[14:0]};
    end
endmodule

// bfloat16 add, round-to-nearest-even with guard/round/sticky, subnormals flushed to zero.
// Latency: combinational.
// Backpressure: none.
module bfloat16Add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic [15:0]       x, z;
    logic              a_nan, b_nan, a_inf, b_inf, sub, s_zero, found, up;
    logic [7:0]        d;
    logic [10:0]       mx, mz, sh;
    logic [11:0]       s;
    logic [3:0]        lz;
    logic signed [9:0] e;
    logic [16:0]       r;

    always_comb begin
        a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
        b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
        a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
        b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
        if (a[14:0] < b[14:0]) begin
            x = b;
            z = a;
        end else begin
            x = a;
            z = b;
        end
        d  = x[14:7] - z[14:7];
        mx = {1'b1, x[6:0], 3'b000};
        mz = {1'b1, z[6:0], 3'b000};
        // Bits shifted out of the smaller operand collapse into the sticky LSB.
        if (d > 8'd10)
            sh = 11'd1;
        else
            sh = (mz >> d) | {10'd0, |(mz & ~(11'h7FF << d))};
        sub    = x[15] ^ z[15];
        s      = sub ? ({1'b0, mx} - {1'b0, sh}) : ({1'b0, mx} + {1'b0, sh});
        s_zero = (s == 12'd0);
        e      = $signed({2'b00, x[14:7]});
        lz     = 4'd0;
        found  = 1'b0;
        if (s[11]) begin
            s = {1'b0, s[11:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            for (int i = 10; i >= 0; i--) begin
                if (!found) begin
                    if (s[i])
                        found = 1'b1;
                    else
                        lz = lz + 4'd1;
                end
            end
            s = s << lz;
            e = e - $signed({6'd0, lz});
        end
        up = s[2] & (s[1] | s[0] | s[3]);
        r  = {e, s[9:3]} + {16'd0, up};
        if (a_nan | b_nan | (a_inf & b_inf & (a[15] ^ b[15])))
            y = 16'h7FC0;
        else if (a_inf | b_inf)
            y = a_inf ? a : b;
        else if (x[14:7] == 8'd0)
            y = {a[15] & b[15], 15'd0};
        else if (z[14:7] == 8'd0)
            y = x;
        else if (s_zero)
            y = 16'h0000;
        else if ($signed(r[16:7]) >= 10'sd255)
            y = {x[15], 8'hFF, 7'd0};
        else if ($signed(r[16:7]) <= 10'sd0)
            y = {x[15], 15'd0};
        else
            y = {x[15], r[14:0]};
    end
endmodule

// File: tb/tb_pe_os_mac.sv
// Scoreboard bench for pe_os_mac: reference model uses double-precision arithmetic rounded to bfloat16.
module tb_pe_os_mac;
    localparam int N  = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic          vld;
        logic          clr;
        logic [15:0]   row;
        logic [15:0]   col;
        logic [15:0]   res;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iValid = 1'b0, iClear = 1'b0, iDrain = 1'b0;
    logic [15:0]   iRow = '0, iCol = '0, iRes = '0;
    logic          oValid, oClear, oDone;
    logic [15:0]   oRow, oCol, oRes;
    logic [CW-1:0] oCnt;

    int n_vec = 0;
    int n_err = 0;

    exp_t        exp_q[$];
    logic [15:0] res_q[$];

    logic [15:0] m_acc = '0, m_res = '0, m_row = '0, m_col = '0;
    int          m_cnt = 0;

    pe_os_mac #(.BW(16), .N(N)) dut (
        .clk(clk), .rst(rst), .iValid(iValid), .iClear(iClear),
        .iRow(iRow), .iCol(iCol), .iDrain(iDrain), .iRes(iRes),
        .oValid(oValid), .oClear(oClear), .oRow(oRow), .oCol(oCol),
        .oRes(oRes), .oDone(oDone), .oCnt(oCnt)
    );

    always #5 clk = ~clk;

    function automatic real bf2r(input logic [15:0] b);
        logic [63:0] d;
        if (b[14:7] == 8'd0)
            return 0.0;
        d = {b[15], 11'(b[14:7]) + 11'd896, b[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [14:0] body;
        d = $realtobits(r);
        if (d[62:52] == 11'd0)
            return {d[63], 15'd0};
        body = {8'(d[62:52] - 11'd896), d[51:45]};
        if (d[44] && ((|d[43:0]) || body[0]))
            body = body + 15'd1;
        return {d[63], body};
    endfunction

    function automatic logic [15:0] rnd_bf();
        return {1'($urandom), 8'($urandom_range(132, 122)), 7'($urandom)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus and record what the PE must show after the next edge.
    task automatic step(input logic v, input logic c, input logic [15:0] row, input logic [15:0] col,
                        input logic dr, input logic [15:0] ires);
        logic [15:0] sum;
        int          nxt;
        logic        done;
        @(negedge clk);
        iValid = v; iClear = c; iRow = row; iCol = col; iDrain = dr; iRes = ires;
        done = 1'b0;
        if (v) begin
            sum = r2bf((c ? 0.0 : bf2r(m_acc)) + bf2r(r2bf(bf2r(row) * bf2r(col))));
            nxt = c ? 1 : m_cnt + 1;
            if (nxt == N) begin
                done  = 1'b1;
                m_res = sum;
                m_acc = '0;
                m_cnt = 0;
                res_q.push_back(sum);
            end else begin
                m_acc = sum;
                m_cnt = nxt;
            end
            m_row = row;
            m_col = col;
        end else if (c) begin
            m_acc = '0;
            m_cnt = 0;
        end
        if (dr && !done)
            m_res = ires;
        exp_q.push_back('{v, v & c, m_row, m_col, m_res, done, CW'(m_cnt)});
    endtask

    task automatic stream(input int gap, input logic dr_last, input logic [15:0] ires);
        logic [15:0] rows [4];
        rows = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
        for (int t = 0; t < 4; t++) begin
            if (t == 2)
                for (int g = 0; g < gap; g++)
                    step(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b0, 16'h0);
            step(1'b1, t == 0, rows[t], 16'h3F80, (t == 3) && dr_last, ires);
        end
    endtask

    initial begin : monitor
        exp_t        e;
        logic [15:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({oValid, oClear, oRow, oCol, oRes, oDone, oCnt} !== e) begin
                    n_err++;
                    $display("FAIL cycle_state: got vld=%b clr=%b row=%h col=%h res=%h done=%b cnt=%0d, expected vld=%b clr=%b row=%h col=%h res=%h done=%b cnt=%0d",
                             oValid, oClear, oRow, oCol, oRes, oDone, oCnt,
                             e.vld, e.clr, e.row, e.col, e.res, e.done, e.cnt);
                end
            end
            if (oDone === 1'b1) begin
                n_vec++;
                if (res_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got oDone=1 with oRes=%h, expected no result", oRes);
                end else begin
                    r = res_q.pop_front();
                    if (oRes !== r) begin
                        n_err++;
                        $display("FAIL result: got %h, expected %h", oRes, r);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : driver
        logic v, c, dr;
        #7;
        chk("reset_state", {oValid, oClear, oRow, oCol, oRes, oDone, oCnt}, '0);
        @(negedge clk);
        rst = 1'b0;

        stream(0, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("n4_res", oRes, 16'h4120);
        chk("n4_done", oDone, 1'b1);
        chk("n4_cnt", oCnt, '0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("n4_done_once", oDone, 1'b0);

        stream(2, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("gap_res", oRes, 16'h4120);

        step(1'b1, 1'b1, 16'h4000, 16'h4000, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h4000, 16'h4000, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h3F00, 16'h4000, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("restart_cnt", oCnt, 2'd1);
        chk("restart_no_done", oDone, 1'b0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 16'h3F80, 16'h3F80, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("restart_res", oRes, 16'h4080);

        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h4000);
        @(posedge clk); #2;
        chk("drain_step", oRes, 16'h4000);
        stream(0, 1'b1, 16'h1234);
        @(posedge clk); #2;
        chk("capture_beats_drain", oRes, 16'h4120);

        step(1'b1, 1'b1, 16'h3F80, 16'h3F80, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h3F80, 16'h3F80, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("pre_reset_cnt", oCnt, 2'd2);
        @(negedge clk);
        iValid = 1'b0; iClear = 1'b0; iDrain = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_reset", {oValid, oClear, oRow, oCol, oRes, oDone, oCnt}, '0);
        @(negedge clk);
        rst = 1'b0;
        m_acc = '0; m_res = '0; m_row = '0; m_col = '0; m_cnt = 0;
        stream(0, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("post_reset_res", oRes, 16'h4120);

        for (int k = 0; k < 400; k++) begin
            v  = ($urandom_range(3) != 0);
            c  = v && ((m_cnt == 0 && $urandom_range(3) != 0) || $urandom_range(15) == 0);
            if (!v && $urandom_range(19) == 0)
                c = 1'b1;
            dr = ($urandom_range(7) == 0);
            step(v, c, rnd_bf(), rnd_bf(), dr, 16'($urandom));
        end
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        @(posedge clk); #2;
        chk("results_drained", 32'(res_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
